// File: rtl/riscv_nn_apu_disp_pkg.sv
// Shared types for the APU dispatcher: latency classes and in-flight queue entries.
// The queue entry address width is fixed by DISP_ADDR_W. The top-level ADDR_W
// parameter must not exceed it.
package riscv_nn_apu_disp_pkg;

    localparam int unsigned DISP_ADDR_W = 6;

    typedef enum logic [1:0] {
        LAT_VAR = 2'd0,
        LAT_1   = 2'd1,
        LAT_2   = 2'd2,
        LAT_MC  = 2'd3
    } apu_lat_e;

    typedef struct packed {
        logic [DISP_ADDR_W-1:0] addr;
        apu_lat_e               lat;
    } disp_entry_t;

    // True for classes whose completion time is not fixed: multicycle or variable.
    function automatic logic lat_is_long(input apu_lat_e lat);
        return (lat == LAT_MC) || (lat == LAT_VAR);
    endfunction

endpackage

// File: rtl/riscv_nn_apu_disp_fifo.sv
// In-order circular buffer of outstanding APU operations.
// Pushes at the write pointer and pops at the read pointer. It exports the
// head entry, every slot address and a per-slot valid vector so that the
// dispatcher can run dependency checks against all in-flight destinations.
module riscv_nn_apu_disp_fifo
    import riscv_nn_apu_disp_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  disp_entry_t            entry_i,
    input  logic                   pop_i,
    output disp_entry_t            head_o,
    output logic [DISP_ADDR_W-1:0] addrs_o [DEPTH],
    output logic [DEPTH-1:0]       valid_o,
    output logic [PTR_W-1:0]       rd_ptr_o,
    output logic [CNT_W-1:0]       count_o,
    output logic                   empty_o
);

    disp_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] push_mask;
    logic [DEPTH-1:0] pop_mask;

    assign push_mask = push_i ? (DEPTH'(1) << wr_ptr_q) : '0;
    assign pop_mask  = pop_i  ? (DEPTH'(1) << rd_ptr_q) : '0;

    // Entry storage. A write happens only on push.
    // NOTE: storage is deliberately left without reset. valid_q alone says which slots hold live data.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    // Pointers, occupancy count and per-slot valid bits. Pointers wrap naturally because DEPTH is a power of two.
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_i && !push_i) begin
                count_q <= count_q - CNT_W'(1);
            end
            valid_q <= (valid_q & ~pop_mask) | push_mask;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_addrs
        assign addrs_o[i] = mem_q[i].addr;
    end

    assign head_o   = mem_q[rd_ptr_q];
    assign valid_o  = valid_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;
    assign empty_o  = (count_q == '0);

endmodule

// File: rtl/riscv_nn_apu_disp_q.sv
// APU dispatcher with an in-order in-flight queue of DEPTH entries.
// It issues req/gnt handshakes, returns the write-back address on each response,
// and produces stall, RAW/WAW dependency and perf signals for the decoder.
// Optional: define APU_DISP_OCC_MON_EN to make occ_max_o report the occupancy high-water mark.
module riscv_nn_apu_disp_q
    import riscv_nn_apu_disp_pkg::*;
#(
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned ADDR_W = DISP_ADDR_W,
    parameter  int unsigned N_RD   = 3,
    parameter  int unsigned N_WR   = 2,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic [1:0]             apu_lat_i,
    input  logic [ADDR_W-1:0]      apu_waddr_i,
    output logic [ADDR_W-1:0]      apu_waddr_o,
    output logic                   apu_multicycle_o,
    output logic                   apu_singlecycle_o,
    output logic                   active_o,
    output logic                   stall_o,
    input  logic                   is_decoding_i,
    input  logic [N_RD*ADDR_W-1:0] read_regs_i,
    input  logic [N_RD-1:0]        read_regs_valid_i,
    output logic                   read_dep_o,
    input  logic [N_WR*ADDR_W-1:0] write_regs_i,
    input  logic [N_WR-1:0]        write_regs_valid_i,
    output logic                   write_dep_o,
    output logic                   perf_type_o,
    output logic                   perf_cont_o,
    output logic [CNT_W-1:0]       occ_max_o,
    output logic                   apu_master_req_o,
    output logic                   apu_master_ready_o,
    input  logic                   apu_master_gnt_i,
    input  logic                   apu_master_valid_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    apu_lat_e               lat_in;
    apu_lat_e               last_lat_q;
    disp_entry_t            push_entry;
    disp_entry_t            head;
    logic [DISP_ADDR_W-1:0] slot_addr [DEPTH];
    logic [DEPTH-1:0]       slot_valid;
    logic [DEPTH-1:0]       slot_live;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   empty;
    logic                   full;
    logic                   stall_full;
    logic                   stall_type;
    logic                   stall_nack;
    logic                   valid_req;
    logic                   returned_req;
    logic                   returned_head;
    logic                   req_live;
    logic                   push;
    logic                   pop;
    logic                   read_hit;
    logic                   write_hit;

    assign lat_in     = apu_lat_e'(apu_lat_i);
    assign push_entry = '{addr: DISP_ADDR_W'(apu_waddr_i), lat: lat_in};
    assign full       = (count == CNT_W'(DEPTH));

    riscv_nn_apu_disp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_i   (push),
        .entry_i  (push_entry),
        .pop_i    (pop),
        .head_o   (head),
        .addrs_o  (slot_addr),
        .valid_o  (slot_valid),
        .rd_ptr_o (rd_ptr),
        .count_o  (count),
        .empty_o  (empty)
    );

    // Stall terms. Full-queue stall ignores a same-cycle pop.
    // Type stall keeps fixed-latency results from overtaking in-flight ops.
    assign stall_full = enable_i & full;
    assign stall_type = enable_i & ~empty &
                        ((lat_in == LAT_1) | ((lat_in == LAT_2) & (last_lat_q == LAT_MC)) |
                         (last_lat_q == LAT_VAR) | (lat_in == LAT_VAR));
    assign valid_req  = enable_i & ~stall_type & ~stall_full;
    assign stall_nack = valid_req & ~apu_master_gnt_i;

    // Response handling. A response on an empty queue belongs to the request issued this cycle.
    assign returned_req  = valid_req & apu_master_valid_i & empty;
    assign returned_head = apu_master_valid_i & ~empty;
    assign push          = valid_req & apu_master_gnt_i & ~returned_req;
    assign pop           = returned_head;

    assign apu_waddr_o = returned_req  ? apu_waddr_i :
                         returned_head ? ADDR_W'(head.addr) : '0;

    assign apu_master_req_o   = valid_req;
    assign apu_master_ready_o = 1'b1;
    assign stall_o            = stall_type | stall_full | stall_nack;
    assign perf_type_o        = stall_type | stall_full;
    assign perf_cont_o        = stall_nack;
    assign active_o           = ~empty;
    assign apu_singlecycle_o  = empty;
    assign apu_multicycle_o   = ~empty & lat_is_long(head.lat);

    // The head slot stops counting as a hazard in the cycle it returns. The
    // request only counts when it will actually be tracked.
    assign slot_live = slot_valid & ~(pop ? (DEPTH'(1) << rd_ptr) : '0);
    assign req_live  = valid_req & ~returned_req;

    // RAW/WAW match of decoder ports against the request and all live in-flight destinations.
    // NOTE: both hit flags get a default before any conditional update, so no path leaves them unassigned and no latch is inferred.
    always_comb begin
        read_hit  = 1'b0;
        write_hit = 1'b0;
        for (int p = 0; p < N_RD; p++) begin
            if (read_regs_valid_i[p]) begin
                if (req_live && (apu_waddr_i == read_regs_i[p*ADDR_W +: ADDR_W])) begin
                    read_hit = 1'b1;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (slot_live[i] && (slot_addr[i] == DISP_ADDR_W'(read_regs_i[p*ADDR_W +: ADDR_W]))) begin
                        read_hit = 1'b1;
                    end
                end
            end
        end
        for (int p = 0; p < N_WR; p++) begin
            if (write_regs_valid_i[p]) begin
                if (req_live && (apu_waddr_i == write_regs_i[p*ADDR_W +: ADDR_W])) begin
                    write_hit = 1'b1;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (slot_live[i] && (slot_addr[i] == DISP_ADDR_W'(write_regs_i[p*ADDR_W +: ADDR_W]))) begin
                        write_hit = 1'b1;
                    end
                end
            end
        end
    end

    assign read_dep_o  = is_decoding_i & read_hit;
    assign write_dep_o = is_decoding_i & write_hit;

    // Latency class of the most recently issued request, used by the type stall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_lat_q <= LAT_VAR;
        end else if (valid_req) begin
            last_lat_q <= lat_in;
        end
    end

`ifdef APU_DISP_OCC_MON_EN
    logic [CNT_W-1:0] occ_max_q;

    // High-water mark of the registered count. It follows count one cycle later and cannot exceed DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_max_q <= '0;
        end else if (count > occ_max_q) begin
            occ_max_q <= count;
        end
    end

    assign occ_max_o = occ_max_q;
`else
    assign occ_max_o = '0;
`endif

    // A response with nothing in flight and no same-cycle request is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            unexpected_rsp: assert (!(apu_master_valid_i && empty && !valid_req))
                else $warning("apu dispatcher: response with empty queue ignored");
        end
    end

endmodule
